// File: rtl/scatter_pkg.sv
// scatter_pkg: shared types and helpers for the A-operand scatter stream.
//   state_t    - FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2, WAIT_NEXT=3)
//   calc_beats - BRAM words needed to build one N*W row vector
//   idx_w      - bits needed to index 0..n-1 (minimum 1)
package scatter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    DRAIN     = 3'd2,
    WAIT_NEXT = 3'd3
  } state_t;

  function automatic int calc_beats(input int n, input int w, input int bram_w);
    return (n * w) / bram_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scatter_vec_fifo.sv
// scatter_vec_fifo: synchronous first-word-fall-through FIFO for row vectors.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (empties the FIFO)
//   push, din    - write one entry (ignored when full)
//   pop          - discard the head entry (ignored when empty)
//   dout         - head entry, valid whenever empty is low
//   empty        - no entries held
//   count        - current occupancy, 0..DEPTH
module scatter_vec_fifo
  import scatter_pkg::*;
#(
  parameter int DW    = 33,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = idx_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (32'(count) == DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scatter_a_stream.sv
// scatter_a_stream: streams the row vectors of one A column block from a
// read-only BRAM port into the N-lane systolic array a_in row.
//
// Optional build macro: SCATTER_A_SKEW_EN - adds an output skew stage that
// delays lane j by j transfers and appends N-1 zero-filled flush vectors at
// the end of each block (a_last then marks the final flush vector).
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start                    - begin next column block (IDLE or WAIT_NEXT)
//   cfg_base_addr/cfg_rows/cfg_col_blocks - geometry, sampled at start in IDLE
//   bram_*_a                 - read-only BRAM port A (we/wrdata tied to 0)
//   a_valid/a_ready/a_data/a_last - vector stream to the PE array
//   blk_done, all_done       - one-cycle completion pulses
//   busy, dbg_state, dbg_row, dbg_cblk - status and debug
module scatter_a_stream
  import scatter_pkg::*;
#(
  parameter int W        = 8,
  parameter int N        = 64,
  parameter int BRAM_W   = 128,
  parameter int BRAM_AW  = 9,
  parameter int RD_LAT   = 1,
  parameter int MAX_ROWS = 1024,
  parameter int MAX_CBLK = 16,
  parameter int FIFO_D   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BRAM_AW-1:0]            cfg_base_addr,
  input  logic [$clog2(MAX_ROWS+1)-1:0] cfg_rows,
  input  logic [$clog2(MAX_CBLK+1)-1:0] cfg_col_blocks,
  output logic                          bram_clk_a,
  output logic                          bram_we_a,
  output logic                          bram_en_a,
  output logic [BRAM_AW-1:0]            bram_addr_a,
  output logic [BRAM_W-1:0]             bram_wrdata_a,
  input  logic [BRAM_W-1:0]             bram_rddata_a,
  output logic                          a_valid,
  input  logic                          a_ready,
  output logic [N*W-1:0]                a_data,
  output logic                          a_last,
  output logic                          blk_done,
  output logic                          all_done,
  output logic                          busy,
  output logic [2:0]                    dbg_state,
  output logic [$clog2(MAX_ROWS)-1:0]   dbg_row,
  output logic [$clog2(MAX_CBLK)-1:0]   dbg_cblk
);

  localparam int VW    = N * W;
  localparam int BEATS = calc_beats(N, W, BRAM_W);
  localparam int RW    = $clog2(MAX_ROWS + 1);
  localparam int RIW   = $clog2(MAX_ROWS);
  localparam int CW    = $clog2(MAX_CBLK + 1);
  localparam int CIW   = $clog2(MAX_CBLK);
  localparam int BTW   = idx_w(BEATS);
  localparam int FCW   = $clog2(FIFO_D + 1);

  state_t             state;
  logic [RW-1:0]      rows_r;
  logic [CW-1:0]      cblks_r;
  logic [BRAM_AW-1:0] stride_r;
  logic [BRAM_AW-1:0] blk_addr;
  logic [BRAM_AW-1:0] row_addr;
  logic [BRAM_AW-1:0] iss_addr;
  logic [RIW-1:0]     row;
  logic [CIW-1:0]     cblk;
  logic [BTW-1:0]     beat;
  logic               iss_lastbeat;
  logic               iss_lastrow;
  logic [FCW-1:0]     inflight;

  logic               row_is_last;
  logic               beat_is_last;
  logic               blk_is_last;
  logic               credit_ok;
  logic               issue_go;
  logic               first_go;

  logic [RD_LAT-1:0]  pipe_vld;
  logic [RD_LAT-1:0]  pipe_lastbeat;
  logic [RD_LAT-1:0]  pipe_lastrow;
  logic               ret_vld;
  logic               ret_lastbeat;
  logic               ret_lastrow;
  logic [VW-1:0]      row_vec;

  logic               fifo_push;
  logic               fifo_pop;
  logic [VW:0]        fifo_dout;
  logic               fifo_empty;
  logic [FCW-1:0]     fifo_count;
  logic               out_xfer;

  assign bram_clk_a    = clk;
  assign bram_we_a     = 1'b0;
  assign bram_wrdata_a = '0;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;
  assign dbg_row       = row;
  assign dbg_cblk      = cblk;

  assign row_is_last  = (32'(row) == 32'(rows_r) - 32'd1);
  assign beat_is_last = (32'(beat) == BEATS - 1);
  assign blk_is_last  = (32'(cblk) == 32'(cblks_r) - 32'd1);
  // Rows already committed (in flight or buffered) must leave room for one more.
  assign credit_ok    = (32'(inflight) + 32'(fifo_count)) < 32'(FIFO_D);
  assign issue_go     = (state == ISSUE) && ((beat != '0) || credit_ok);
  assign first_go     = issue_go && (beat == '0);
  assign out_xfer     = a_valid && a_ready;

  // ---- stage p0: control FSM and address issue ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rows_r       <= '0;
      cblks_r      <= '0;
      stride_r     <= '0;
      blk_addr     <= '0;
      row_addr     <= '0;
      iss_addr     <= '0;
      row          <= '0;
      cblk         <= '0;
      beat         <= '0;
      bram_en_a    <= 1'b0;
      bram_addr_a  <= '0;
      iss_lastbeat <= 1'b0;
      iss_lastrow  <= 1'b0;
      blk_done     <= 1'b0;
      all_done     <= 1'b0;
    end else begin
      bram_en_a <= 1'b0;
      blk_done  <= 1'b0;
      all_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rows_r   <= cfg_rows;
            cblks_r  <= cfg_col_blocks;
            stride_r <= BRAM_AW'(32'(cfg_col_blocks) * BEATS);
            blk_addr <= cfg_base_addr;
            row_addr <= cfg_base_addr;
            iss_addr <= cfg_base_addr;
            row      <= '0;
            cblk     <= '0;
            beat     <= '0;
            // An empty geometry completes immediately without leaving IDLE.
            if (cfg_rows == '0 || cfg_col_blocks == '0) all_done <= 1'b1;
            else                                        state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_go) begin
            bram_en_a    <= 1'b1;
            bram_addr_a  <= iss_addr;
            iss_lastbeat <= beat_is_last;
            iss_lastrow  <= row_is_last;
            if (beat_is_last) begin
              beat     <= '0;
              row_addr <= row_addr + stride_r;
              iss_addr <= row_addr + stride_r;
              if (row_is_last) state <= DRAIN;
              else             row   <= row + 1'b1;
            end else begin
              beat     <= beat + 1'b1;
              iss_addr <= iss_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The final vector of a block can only transfer once every read
          // has returned, so its handshake alone marks the block complete.
          if (out_xfer && a_last) begin
            blk_done <= 1'b1;
            if (blk_is_last) begin
              all_done <= 1'b1;
              state    <= IDLE;
            end else begin
              cblk     <= cblk + 1'b1;
              blk_addr <= blk_addr + BRAM_AW'(BEATS);
              row_addr <= blk_addr + BRAM_AW'(BEATS);
              iss_addr <= blk_addr + BRAM_AW'(BEATS);
              state    <= WAIT_NEXT;
            end
          end
        end
        WAIT_NEXT: begin
          if (start) begin
            row   <= '0;
            beat  <= '0;
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({first_go, fifo_push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // ---- stage p1: BRAM read latency tracking ----
  always_ff @(posedge clk) begin
    if (rst) pipe_vld <= '0;
    else     pipe_vld <= RD_LAT'({pipe_vld, bram_en_a});
  end

  always_ff @(posedge clk) begin
    pipe_lastbeat <= RD_LAT'({pipe_lastbeat, iss_lastbeat});
    pipe_lastrow  <= RD_LAT'({pipe_lastrow, iss_lastrow});
  end

  assign ret_vld      = pipe_vld[RD_LAT-1];
  assign ret_lastbeat = pipe_lastbeat[RD_LAT-1];
  assign ret_lastrow  = pipe_lastrow[RD_LAT-1];

  // ---- stage p2: row assembly, beat 0 ends up in the lowest lanes ----
  generate
    if (BEATS == 1) begin : g_one_beat
      assign row_vec = bram_rddata_a;
    end else begin : g_multi_beat
      logic [VW-BRAM_W-1:0] asm_r;
      always_ff @(posedge clk) begin
        if (ret_vld) asm_r <= row_vec[VW-1:BRAM_W];
      end
      assign row_vec = {bram_rddata_a, asm_r};
    end
  endgenerate

  assign fifo_push = ret_vld && ret_lastbeat;

  scatter_vec_fifo #(
    .DW    (VW + 1),
    .DEPTH (FIFO_D),
    .CW    (FCW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({ret_lastrow, row_vec}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---- stage p3: output presentation ----
`ifdef SCATTER_A_SKEW_EN
  localparam int FLW = idx_w(N);

  logic           flushing;
  logic [FLW-1:0] flush_cnt;
  logic [VW-1:0]  skew_src;
  logic [VW-1:0]  skew_out;

  // Once the block's last row has left the FIFO, zeros are fed in for N-1
  // further transfers so every delayed lane empties.
  assign skew_src = flushing ? '0 : fifo_dout[VW-1:0];
  assign a_valid  = !fifo_empty || flushing;
  assign a_last   = flushing && (32'(flush_cnt) == N - 2);
  assign a_data   = a_valid ? skew_out : '0;
  assign fifo_pop = a_ready && !fifo_empty && !flushing;

  assign skew_out[W-1:0] = skew_src[W-1:0];

  for (genvar j = 1; j < N; j++) begin : g_lane
    logic [W-1:0] dl [j];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < j; k++) dl[k] <= '0;
      end else if (out_xfer) begin
        dl[0] <= skew_src[W*j +: W];
        for (int k = 1; k < j; k++) dl[k] <= dl[k-1];
      end
    end
    assign skew_out[W*j +: W] = dl[j-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flushing  <= 1'b0;
      flush_cnt <= '0;
    end else if (!flushing) begin
      if (out_xfer && fifo_dout[VW]) begin
        flushing  <= 1'b1;
        flush_cnt <= '0;
      end
    end else if (out_xfer) begin
      if (32'(flush_cnt) == N - 2) flushing  <= 1'b0;
      else                         flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign a_valid  = !fifo_empty;
  assign a_data   = fifo_empty ? '0 : fifo_dout[VW-1:0];
  assign a_last   = !fifo_empty && fifo_dout[VW];
  assign fifo_pop = a_ready && !fifo_empty;
`endif

endmodule

// File: tb/tb_scatter_a_stream.sv
module tb_scatter_a_stream;

  localparam int W        = 8;
  localparam int N        = 4;
  localparam int BRAM_W   = 16;
  localparam int BRAM_AW  = 6;
  localparam int RD_LAT   = 2;
  localparam int MAX_ROWS = 16;
  localparam int MAX_CBLK = 4;
  localparam int FIFO_D   = 4;
  localparam int BEATS    = N * W / BRAM_W;
  localparam int VW       = N * W;
  localparam int MEMSZ    = 1 << BRAM_AW;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          start;
  logic [BRAM_AW-1:0]            cfg_base_addr;
  logic [$clog2(MAX_ROWS+1)-1:0] cfg_rows;
  logic [$clog2(MAX_CBLK+1)-1:0] cfg_col_blocks;
  logic                          bram_clk_a;
  logic                          bram_we_a;
  logic                          bram_en_a;
  logic [BRAM_AW-1:0]            bram_addr_a;
  logic [BRAM_W-1:0]             bram_wrdata_a;
  logic [BRAM_W-1:0]             bram_rddata_a;
  logic                          a_valid;
  logic                          a_ready;
  logic [VW-1:0]                 a_data;
  logic                          a_last;
  logic                          blk_done;
  logic                          all_done;
  logic                          busy;
  logic [2:0]                    dbg_state;
  logic [$clog2(MAX_ROWS)-1:0]   dbg_row;
  logic [$clog2(MAX_CBLK)-1:0]   dbg_cblk;

  always #5 clk = ~clk;

  scatter_a_stream #(
    .W(W), .N(N), .BRAM_W(BRAM_W), .BRAM_AW(BRAM_AW), .RD_LAT(RD_LAT),
    .MAX_ROWS(MAX_ROWS), .MAX_CBLK(MAX_CBLK), .FIFO_D(FIFO_D)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_rows(cfg_rows), .cfg_col_blocks(cfg_col_blocks),
    .bram_clk_a(bram_clk_a), .bram_we_a(bram_we_a), .bram_en_a(bram_en_a),
    .bram_addr_a(bram_addr_a), .bram_wrdata_a(bram_wrdata_a), .bram_rddata_a(bram_rddata_a),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .blk_done(blk_done), .all_done(all_done), .busy(busy),
    .dbg_state(dbg_state), .dbg_row(dbg_row), .dbg_cblk(dbg_cblk)
  );

  // Behavioural BRAM: data for the address presented in cycle t appears in cycle t+RD_LAT.
  logic [BRAM_W-1:0] mem [MEMSZ];
  logic [BRAM_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= bram_en_a ? mem[bram_addr_a] : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rddata_a = rd_pipe[RD_LAT-1];

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int nblk = 0;
  int nall = 0;
  int issued = 0;
  int xfers = 0;
  int rows_cur = 0;
  int first_issue = -1;
  int first_valid = -1;
  int xcyc [3];
  int stall_left = 0;
  int stall_arm = -1;
  bit rnd_ready = 0;
  bit stall_prev = 0;
  logic [VW:0] prev_out;
  logic [BRAM_AW-1:0] exp_addr [$];
  logic [VW:0]        exp_vec [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: expected read addresses and output vectors of one block.
  task automatic plan_block(input int base, input int rows, input int cb, input int c);
    logic [VW-1:0] v [$];
    logic [VW-1:0] vec;
    logic [VW-1:0] tmp;
    logic [VW-1:0] o;
    int a;
    for (int r = 0; r < rows; r++) begin
      vec = '0;
      for (int b = 0; b < BEATS; b++) begin
        a = (base + (r * cb + c) * BEATS + b) % MEMSZ;
        exp_addr.push_back(BRAM_AW'(a));
        vec[b*BRAM_W +: BRAM_W] = mem[a];
      end
      v.push_back(vec);
    end
`ifdef SCATTER_A_SKEW_EN
    for (int k = 0; k < rows + N - 1; k++) begin
      o = '0;
      for (int j = 0; j < N; j++) begin
        if (k - j >= 0 && k - j < rows) begin
          tmp = v[k-j];
          o[j*W +: W] = tmp[j*W +: W];
        end
      end
      exp_vec.push_back({(k == rows + N - 2), o});
    end
`else
    for (int r = 0; r < rows; r++) exp_vec.push_back({(r == rows - 1), v[r]});
`endif
    rows_cur = rows;
    issued = 0;
    xfers = 0;
    first_issue = -1;
    first_valid = -1;
  endtask

  // One clock: advance past the edge, pick a_ready, then check what the DUT shows.
  task automatic step();
    logic [VW:0] e;
    int done_rows;
    @(posedge clk);
    #1;
    cyc++;
    if (stall_arm >= 0 && xfers == stall_arm) begin
      stall_left = 10;
      stall_arm = -1;
    end
    if (stall_left > 0) begin
      a_ready = 1'b0;
      stall_left--;
    end else if (rnd_ready) a_ready = ($urandom_range(0, 3) != 0);
    else a_ready = 1'b1;

    if (bram_en_a) begin
      if (first_issue < 0) first_issue = cyc;
      if (exp_addr.size() == 0) chk("addr_unexpected", 1, 0);
      else chk("addr", bram_addr_a, exp_addr.pop_front());
      issued++;
    end
    if (stall_prev && !rst) begin
      chk("hold_valid", a_valid, 1);
      chk("hold_data", {a_last, a_data}, prev_out);
    end
    if (!a_valid) chk("idle_zero", {a_last, a_data}, 0);
    else if (first_valid < 0) first_valid = cyc;
    if (a_valid && !a_ready) begin
      done_rows = (xfers < rows_cur) ? xfers : rows_cur;
      chk("credit", ((issued + BEATS - 1) / BEATS - done_rows) <= FIFO_D, 1);
    end
    if (a_valid && a_ready) begin
      if (exp_vec.size() == 0) chk("vec_unexpected", 1, 0);
      else begin
        e = exp_vec.pop_front();
        chk("vec", {a_last, a_data}, e);
      end
      if (xfers < 3) xcyc[xfers] = cyc;
      xfers++;
    end
    stall_prev = a_valid && !a_ready;
    prev_out = {a_last, a_data};
    if (blk_done) nblk++;
    if (all_done) nall++;
  endtask

  task automatic run_block(input int base, input int rows, input int cb, input int c, input bit last_blk);
    int nb0;
    int na0;
    int t;
    plan_block(base, rows, cb, c);
    nb0 = nblk;
    na0 = nall;
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    while (nblk == nb0 && t < 3000) begin
      step();
      t++;
    end
    chk("blk_done_count", nblk - nb0, 1);
    chk("all_done_count", nall - na0, last_blk);
    chk("vec_left", exp_vec.size(), 0);
    chk("addr_left", exp_addr.size(), 0);
    chk("state_after_blk", dbg_state, last_blk ? 0 : 3);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", a_valid, 0);
    chk("rst_data", {a_last, a_data}, 0);
    chk("rst_pulses", {blk_done, all_done, busy}, 0);
    chk("rst_dbg", {dbg_state, dbg_row, dbg_cblk}, 0);
    chk("rst_bram", {bram_en_a, bram_we_a, bram_addr_a, bram_wrdata_a}, 0);
  endtask

  initial begin
    int base;
    int rows;
    int cb;
    bit seen_valid;
    for (int i = 0; i < MEMSZ; i++) mem[i] = BRAM_W'($urandom);
    rst = 1'b1;
    start = 1'b0;
    a_ready = 1'b1;
    cfg_base_addr = '0;
    cfg_rows = '0;
    cfg_col_blocks = '0;
    repeat (3) step();
    check_reset_outputs();
    rst = 1'b0;
    step();

    // Directed geometry: base 0, 3 rows, 2 column blocks, consumer always ready.
    cfg_base_addr = 0;
    cfg_rows = 3;
    cfg_col_blocks = 2;
    run_block(0, 3, 2, 0, 0);
    chk("latency", first_valid - first_issue, RD_LAT + BEATS);
    chk("throughput01", xcyc[1] - xcyc[0], BEATS);
    chk("throughput12", xcyc[2] - xcyc[1], BEATS);
    chk("cblk_next", dbg_cblk, 1);
    run_block(0, 3, 2, 1, 1);

    // Empty geometries finish at once and never present data.
    for (int k = 0; k < 2; k++) begin
      cfg_rows = (k == 0) ? 0 : 3;
      cfg_col_blocks = (k == 0) ? 2 : 0;
      nall = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("empty_all_done", {all_done, busy}, 2'b10);
      seen_valid = 0;
      repeat (6) begin
        step();
        seen_valid |= a_valid;
      end
      chk("empty_no_valid", seen_valid, 0);
      chk("empty_one_pulse", nall, 1);
    end

    // Address wrap plus a 10-cycle consumer stall mid-block.
    cfg_base_addr = 60;
    cfg_rows = 8;
    cfg_col_blocks = 1;
    stall_arm = 2;
    run_block(60, 8, 1, 0, 1);

    // Randomised geometry and consumer back-pressure.
    rnd_ready = 1;
    for (int it = 0; it < 4; it++) begin
      base = $urandom_range(0, MEMSZ - 1);
      rows = $urandom_range(1, 6);
      cb = $urandom_range(1, 3);
      cfg_base_addr = BRAM_AW'(base);
      cfg_rows = 5'(rows);
      cfg_col_blocks = 3'(cb);
      for (int c = 0; c < cb; c++) run_block(base, rows, cb, c, (c == cb - 1));
    end
    rnd_ready = 0;

    // Reset during block 1 issue drops the block; a new start replays from block 0.
    cfg_base_addr = 7;
    cfg_rows = 4;
    cfg_col_blocks = 2;
    run_block(7, 4, 2, 0, 0);
    plan_block(7, 4, 2, 1);
    nblk = 0;
    nall = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_state_issue", dbg_state, 1);
    rst = 1'b1;
    step();
    check_reset_outputs();
    rst = 1'b0;
    exp_addr.delete();
    exp_vec.delete();
    repeat (8) step();
    chk("no_done_after_rst", {nblk[3:0], nall[3:0]}, 0);
    run_block(7, 4, 2, 0, 0);
    run_block(7, 4, 2, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
